// File: rtl/pixel_scan_driver_pkg.sv
// rtl/pixel_scan_driver_pkg.sv - shared widths, defaults and scan state encoding for the display path
package pixel_scan_driver_pkg;

    localparam int H_PIXELS_DEF = 160;
    localparam int V_PIXELS_DEF = 120;
    localparam int PIPE_LAT_DEF = 2;

    localparam int COLOR_W = 3;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/pixel_scan_driver_delay_line.sv
// rtl/pixel_scan_driver_delay_line.sv - DEPTH-stage shift register carrying {valid, x, y} alongside the colour pipeline
module scan_delay_line #(
    parameter int DEPTH = 2,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    output logic          tap_valid,
    output logic [XW-1:0] tap_x,
    output logic [YW-1:0] tap_y
);

    logic [DEPTH-1:0] v_q;
    logic [XW-1:0]    x_q [DEPTH];
    logic [YW-1:0]    y_q [DEPTH];

    // Shift one stage per cycle; the last stage lines up with the returned colour
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i] <= 1'b0;
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            x_q[0] <= in_x;
            y_q[0] <= in_y;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                x_q[i] <= x_q[i-1];
                y_q[i] <= y_q[i-1];
            end
        end
    end

    assign tap_valid = v_q[DEPTH-1];
    assign tap_x     = x_q[DEPTH-1];
    assign tap_y     = y_q[DEPTH-1];

endmodule

// File: rtl/pixel_scan_driver.sv
// rtl/pixel_scan_driver.sv - raster scan of X/Y into the colour generator with re-aligned VGA plot output
module pixel_scan_driver
    import pixel_scan_driver_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_PIXELS = V_PIXELS_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic [X_W-1:0]     X,
    output logic [Y_W-1:0]     Y,
    input  logic [COLOR_W-1:0] color_in,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               plot,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [X_W-1:0] X_LAST    = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST    = Y_W'(V_PIXELS - 1);
    localparam logic [2:0]     DRAIN_END = 3'(PIPE_LAT);

    scan_state_t state;
    logic [2:0]  drain_cnt;

    logic           tap_valid;
    logic [X_W-1:0] tap_x;
    logic [Y_W-1:0] tap_y;

    // Scan FSM: counters, busy and the frame-complete pulse, all registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            X          <= '0;
            Y          <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    X <= '0;
                    Y <= '0;
                    if (start) begin
                        state     <= ST_SCAN;
                        busy      <= 1'b1;
                        drain_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (X == X_LAST) begin
                        X <= '0;
                        if (Y == Y_LAST) begin
                            Y     <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            Y <= Y + 1'b1;
                        end
                    end else begin
                        X <= X + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Last pixel needs PIPE_LAT cycles in the delay line plus one output register
                    if (drain_cnt == DRAIN_END) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    scan_delay_line #(
        .DEPTH (PIPE_LAT),
        .XW    (X_W),
        .YW    (Y_W)
    ) u_delay (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (state == ST_SCAN),
        .in_x      (X),
        .in_y      (Y),
        .tap_valid (tap_valid),
        .tap_x     (tap_x),
        .tap_y     (tap_y)
    );

    // Output stage: register coordinate, colour and strobe together for the VGA write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            plot      <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else begin
            plot  <= tap_valid;
            vga_x <= tap_x;
            vga_y <= tap_y;
            if (tap_valid) begin
                vga_color <= color_in;
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_driver.sv
// tb/tb_pixel_scan_driver.sv - scoreboard bench for pixel_scan_driver with random colour table and start/reset timing
module tb_pixel_scan_driver;

    localparam int LAT  = 2;
    localparam int H    = 160;
    localparam int V    = 120;
    localparam int NPIX = H * V;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] X;
    logic [6:0] Y;
    logic [2:0] color_in = 3'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_color;
    logic       plot;
    logic       busy;
    logic       frame_done;

    pixel_scan_driver #(.H_PIXELS(H), .V_PIXELS(V), .PIPE_LAT(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .X          (X),
        .Y          (Y),
        .color_in   (color_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_color  (vga_color),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int c;
        int x;
        int y;
        int col;
    } ev_t;

    ev_t        plot_q[$];
    logic [2:0] ctab [NPIX];
    logic [2:0] hist[$];
    bit         fa = 1'b0;
    int         fs = 0;
    int         done_c = 0;
    int         nchk = 0;
    int         nfail = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model of the colour generator: random table lookup returned LAT cycles later
    always @(negedge clock) begin
        if (int'(X) < H && int'(Y) < V)
            hist.push_front(ctab[int'(Y) * H + int'(X)]);
        else
            hist.push_front(3'd0);
        if (hist.size() > LAT + 1) void'(hist.pop_back());
        color_in = (hist.size() > LAT) ? hist[LAT] : 3'd0;
    end

    // Monitor: compare DUT outputs against the frame model every cycle
    always @(negedge clock) begin
        int  n, xe, ye;
        bit  busy_e, done_e;
        ev_t e;
        #2;
        xe = 0;
        ye = 0;
        if (fa && cyc >= fs + 1 && cyc <= fs + NPIX) begin
            n  = cyc - fs - 1;
            xe = n % H;
            ye = n / H;
        end
        busy_e = fa && cyc >= fs + 1 && cyc <= done_c - 1;
        done_e = fa && cyc == done_c;
        chk("X", X, xe);
        chk("Y", Y, ye);
        chk("busy", busy, busy_e);
        chk("frame_done", frame_done, done_e);
        if (plot_q.size() > 0 && plot_q[0].c == cyc) begin
            e = plot_q.pop_front();
            chk("plot", plot, 1);
            chk("vga_x", vga_x, e.x);
            chk("vga_y", vga_y, e.y);
            chk("vga_color", vga_color, e.col);
        end else begin
            chk("plot_idle", plot, 0);
        end
    end

    task automatic issue_start();
        start = 1'b1;
        if (!(fa && cyc <= done_c)) begin
            fs     = cyc;
            fa     = 1'b1;
            done_c = cyc + NPIX + LAT + 2;
            for (int p = 0; p < NPIX; p++)
                plot_q.push_back('{fs + 1 + p + LAT + 1, p % H, p / H, int'(ctab[p])});
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    initial begin
        int s;
        reset = 1'b1;
        start = 1'b0;
        for (int p = 0; p < NPIX; p++) ctab[p] = 3'($urandom_range(0, 7));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // Frame 1 with ignored re-starts while busy and on the frame_done cycle
        s = cyc;
        issue_start();
        goto(s + 500);
        issue_start();
        goto(done_c);
        issue_start();

        // Frame 2 after a random idle gap, aborted by reset mid-frame
        goto(done_c + $urandom_range(1, 20));
        s = cyc;
        issue_start();
        goto(s + $urandom_range(4000, 6000));
        reset = 1'b1;
        fa    = 1'b0;
        plot_q.delete();
        #1;
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_color", vga_color, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat ($urandom_range(3, 10)) @(negedge clock);

        // Frame 3 redraws from the origin
        issue_start();
        goto(done_c + 5);
        chk("plots_left", plot_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
